// File: rtl/mem_arbiter_if.sv
// Handshake and memory bus bundle between the pipeline and mem_arbiter.
// slave is the arbiter's view; master is the pipeline/memory view.
interface mem_arbiter_if #(
    parameter int AW   = 32,
    parameter int WORD = 32
);
    logic            halt;
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [WORD-1:0] if_rdata;
    logic            if_done;
    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [WORD-1:0] d_wdata;
    logic [WORD-1:0] d_rdata;
    logic            d_done;
    logic            stall;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [WORD-1:0] mem_wdata;
    logic [WORD-1:0] mem_rdata;

    modport slave (
        input  halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_rdata, if_done, d_rdata, d_done, stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done, stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises IF fetches and MEM-stage data
// accesses onto one fixed-latency memory, stalling the pipeline meanwhile.
module mem_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int WORD = 32;
    localparam int CW   = $clog2(LAT) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC_D,
        ACC_I
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD-1:0] if_rdata_q, if_rdata_d;
    logic [WORD-1:0] d_rdata_q, d_rdata_d;
    logic            if_ok_q, if_ok_d;
    logic            d_ok_q, d_ok_d;

    logic d_pend;
    logic i_pend;
    logic stall;

    assign d_pend = bus.d_req & ~d_ok_q;
    assign i_pend = bus.if_req & ~if_ok_q & ~bus.halt;
    assign stall  = d_pend | i_pend | (state_q != IDLE);

    assign bus.stall     = stall;
    assign bus.if_done   = if_ok_q;
    assign bus.d_done    = d_ok_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ok_d     = if_ok_q;
        d_ok_d      = d_ok_q;

        // no stall means the pipeline steps: served flags start over
        if (!stall) begin
            if_ok_d = 1'b0;
            d_ok_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (d_pend) begin
                    state_d     = ACC_D;
                    cnt_d       = CNT_INIT;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end else if (i_pend) begin
                    state_d    = ACC_I;
                    cnt_d      = CNT_INIT;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                end
            end
            ACC_D, ACC_I: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == ACC_D) begin
                        d_ok_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = bus.mem_rdata;
                    end else begin
                        if_ok_d    = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ok_q     <= 1'b0;
            d_ok_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ok_q     <= if_ok_d;
            d_ok_q      <= d_ok_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random-step bench for mem_arbiter at LAT = 1, 2, 3, 4.
// Memory is modelled as a pure function of the address.
module tb_mem_arbiter;
    localparam logic [31:0] DBASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst1, rst2, rst3, rst4;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32)) b1();
    mem_arbiter_if #(.AW(32)) b2();
    mem_arbiter_if #(.AW(32)) b3();
    mem_arbiter_if #(.AW(32)) b4();

    mem_arbiter #(.LAT(1), .AW(32)) d1 (.clk(clk), .rst(rst1), .bus(b1.slave));
    mem_arbiter #(.LAT(2), .AW(32)) d2 (.clk(clk), .rst(rst2), .bus(b2.slave));
    mem_arbiter #(.LAT(3), .AW(32)) d3 (.clk(clk), .rst(rst3), .bus(b3.slave));
    mem_arbiter #(.LAT(4), .AW(32)) d4 (.clk(clk), .rst(rst4), .bus(b4.slave));

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign b1.mem_rdata = memf(b1.mem_addr);
    assign b2.mem_rdata = memf(b2.mem_addr);
    assign b3.mem_rdata = memf(b3.mem_addr);
    assign b4.mem_rdata = memf(b4.mem_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic nxt();
        @(negedge clk);
        #2;
    endtask

    // grant monitor for the random instances (index 0: LAT1, 1: LAT4)
    int dg [2];
    int ig [2];
    int fp [2];
    int run [2];

    task automatic mon(input int k, input logic en, input logic [31:0] a,
                       input int lat);
        if (en) begin
            if (run[k] == 0) begin
                if (dg[k] + ig[k] == 0) fp[k] = a[28] ? 1 : 2;
                if (a[28]) dg[k]++;
                else ig[k]++;
            end
            run[k]++;
        end else begin
            if (run[k] != 0) chk($sformatf("run_len_lat%0d", lat), 32'(run[k]), 32'(lat));
            run[k] = 0;
        end
    endtask

    always @(posedge clk) begin
        #2;
        mon(0, b1.mem_en, b1.mem_addr, 1);
        mon(1, b4.mem_en, b4.mem_addr, 4);
    end

    task automatic drv(input int k, input logic dr, input logic ir,
                       input logic h, input logic we, input logic [31:0] da,
                       input logic [31:0] ia, input logic [31:0] wd);
        if (k == 0) begin
            b1.d_req = dr; b1.if_req = ir; b1.halt = h; b1.d_we = we;
            b1.d_addr = da; b1.if_addr = ia; b1.d_wdata = wd;
        end else begin
            b4.d_req = dr; b4.if_req = ir; b4.halt = h; b4.d_we = we;
            b4.d_addr = da; b4.if_addr = ia; b4.d_wdata = wd;
        end
    endtask

    task automatic fin(input int k, input int lat, input int cyc,
                       input logic dr, input logic ir, input logic h,
                       input logic we, input logic [31:0] da,
                       input logic [31:0] ia, input logic ddone,
                       input logic idone, input logic [31:0] drd,
                       input logic [31:0] ird);
        logic isv;
        isv = ir & ~h;
        chk($sformatf("d_grants_lat%0d", lat), 32'(dg[k]), 32'(dr));
        chk($sformatf("i_grants_lat%0d", lat), 32'(ig[k]), 32'(isv));
        if (dr && isv) chk($sformatf("prio_lat%0d", lat), 32'(fp[k]), 32'd1);
        chk($sformatf("d_done_lat%0d", lat), 32'(ddone), 32'(dr));
        chk($sformatf("i_done_lat%0d", lat), 32'(idone), 32'(isv));
        if (dr && !we) chk($sformatf("d_rdata_lat%0d", lat), drd, memf(da));
        if (isv) chk($sformatf("i_rdata_lat%0d", lat), ird, memf(ia));
        chk($sformatf("step_len_lat%0d", lat), 32'(cyc),
            32'((dr ? lat + 1 : 0) + (isv ? lat + 1 : 0)));
    endtask

    bit          dn [2];
    int          cyc;
    int          cnt;
    logic        dr, ir, h, we;
    logic [31:0] da, ia, wd;

    initial begin
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drv(k, 0, 0, 0, 0, 0, 0, 0);
            dg[k] = 0; ig[k] = 0; fp[k] = 0; run[k] = 0;
        end
        b2.halt = 0; b2.if_req = 1; b2.if_addr = 32'h40;
        b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0;
        b3.halt = 0; b3.if_req = 0; b3.if_addr = 0;
        b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;

        // reset with a fetch already requested
        nxt();
        nxt();
        chk("rst_mem_en", 32'(b2.mem_en), 32'd0);
        chk("rst_mem_addr", b2.mem_addr, 32'd0);
        chk("rst_if_rdata", b2.if_rdata, 32'd0);
        chk("rst_d_rdata", b2.d_rdata, 32'd0);
        chk("rst_if_done", 32'(b2.if_done), 32'd0);
        chk("rst_stall", 32'(b2.stall), 32'd1);
        rst1 = 0; rst2 = 0; rst3 = 0; rst4 = 0;
        for (int c = 1; c <= 4; c++) begin
            nxt();
            chk("t1_mem_en", 32'(b2.mem_en), 32'(c <= 2));
            if (c <= 2) chk("t1_mem_addr", b2.mem_addr, 32'h40);
            chk("t1_if_done", 32'(b2.if_done), 32'(c == 3));
            chk("t1_if_rdata", b2.if_rdata, (c >= 3) ? memf(32'h40) : 32'd0);
            if (c == 3) begin
                chk("t1_stall", 32'(b2.stall), 32'd0);
                b2.if_req = 0;
            end
        end

        // contention: SW to 0x100 and a fetch in the same cycle
        b2.d_req = 1; b2.d_we = 1; b2.d_addr = 32'h100;
        b2.d_wdata = 32'hDEAD_BEEF;
        b2.if_req = 1; b2.if_addr = 32'h44;
        cnt = 0;
        #1;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) nxt();
            chk("t2_stall", 32'(b2.stall), 32'(c < 6));
            chk("t2_mem_en", 32'(b2.mem_en),
                32'((c >= 1 && c <= 2) || (c >= 4 && c <= 5)));
            chk("t2_d_done", 32'(b2.d_done), 32'(c >= 3));
            chk("t2_if_done", 32'(b2.if_done), 32'(c == 6));
            if (b2.mem_en) begin
                chk("t2_mem_addr", b2.mem_addr, (c <= 2) ? 32'h100 : 32'h44);
                chk("t2_mem_we", 32'(b2.mem_we), 32'(c <= 2));
                if (b2.mem_we) begin
                    chk("t2_mem_wdata", b2.mem_wdata, 32'hDEAD_BEEF);
                    cnt++;
                end
            end
        end
        chk("t2_if_rdata", b2.if_rdata, memf(32'h44));
        chk("t2_we_cycles", 32'(cnt), 32'd2);
        b2.d_req = 0; b2.if_req = 0;

        // LW, pipeline advance, then a new LW the next step
        nxt();
        b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h200;
        nxt();
        nxt();
        nxt();
        chk("t3_d_done", 32'(b2.d_done), 32'd1);
        chk("t3_d_rdata", b2.d_rdata, memf(32'h200));
        chk("t3_stall", 32'(b2.stall), 32'd0);
        b2.d_addr = 32'h204;
        nxt();
        chk("t3_d_done_clr", 32'(b2.d_done), 32'd0);
        chk("t3_d_rdata_hold", b2.d_rdata, memf(32'h200));
        chk("t3_stall_new", 32'(b2.stall), 32'd1);
        chk("t3_mem_en_gap", 32'(b2.mem_en), 32'd0);
        nxt();
        chk("t3_regrant_en", 32'(b2.mem_en), 32'd1);
        chk("t3_regrant_addr", b2.mem_addr, 32'h204);
        nxt();
        nxt();
        chk("t3_d_done2", 32'(b2.d_done), 32'd1);
        chk("t3_d_rdata2", b2.d_rdata, memf(32'h204));
        b2.d_req = 0;

        // halt masks fetch; halt raised mid-fetch lets it finish
        nxt();
        b2.halt = 1; b2.if_req = 1; b2.if_addr = 32'h48;
        #1;
        chk("t4_halt_stall", 32'(b2.stall), 32'd0);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            nxt();
            if (b2.mem_en || b2.if_done || b2.stall) cnt++;
        end
        chk("t4_halt_idle", 32'(cnt), 32'd0);
        b2.halt = 0;
        nxt();
        chk("t4_fetch_en", 32'(b2.mem_en), 32'd1);
        chk("t4_fetch_addr", b2.mem_addr, 32'h48);
        b2.halt = 1;
        nxt();
        chk("t4_fetch_hold", 32'(b2.mem_en), 32'd1);
        chk("t4_busy_stall", 32'(b2.stall), 32'd1);
        nxt();
        chk("t4_if_done", 32'(b2.if_done), 32'd1);
        chk("t4_if_rdata", b2.if_rdata, memf(32'h48));
        chk("t4_end_stall", 32'(b2.stall), 32'd0);
        chk("t4_end_en", 32'(b2.mem_en), 32'd0);
        b2.if_req = 0; b2.halt = 0;

        // reset during the first cycle of a LAT=3 data access
        nxt();
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h300;
        nxt();
        chk("t5_mem_en", 32'(b3.mem_en), 32'd1);
        rst3 = 1;
        nxt();
        chk("t5_abort_en", 32'(b3.mem_en), 32'd0);
        chk("t5_state", 32'(d3.state_q), 32'd0);
        b3.d_req = 0;
        rst3 = 0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            nxt();
            if (b3.d_done || b3.mem_en || b3.d_rdata != 0) cnt++;
        end
        chk("t5_no_done", 32'(cnt), 32'd0);

        // random steps on LAT=1 and LAT=4 side by side
        for (int s = 0; s < 60; s++) begin
            nxt();
            dr = 1'($urandom_range(0, 1));
            ir = 1'($urandom_range(0, 1));
            h  = ($urandom_range(0, 3) == 0);
            we = 1'($urandom_range(0, 1));
            da = DBASE | ($urandom & 32'h0000_FFFC);
            ia = $urandom & 32'h0000_FFFC;
            wd = $urandom;
            for (int k = 0; k < 2; k++) begin
                dg[k] = 0; ig[k] = 0; fp[k] = 0; dn[k] = 0;
                drv(k, dr, ir, h, we, da, ia, wd);
            end
            cyc = 0;
            #1;
            while (!(dn[0] && dn[1])) begin
                if (!dn[0] && !b1.stall) begin
                    fin(0, 1, cyc, dr, ir, h, we, da, ia, b1.d_done,
                        b1.if_done, b1.d_rdata, b1.if_rdata);
                    drv(0, 0, 0, h, 0, da, ia, wd);
                    dn[0] = 1;
                end
                if (!dn[1] && !b4.stall) begin
                    fin(1, 4, cyc, dr, ir, h, we, da, ia, b4.d_done,
                        b4.if_done, b4.d_rdata, b4.if_rdata);
                    drv(1, 0, 0, h, 0, da, ia, wd);
                    dn[1] = 1;
                end
                if (!(dn[0] && dn[1])) begin
                    if (cyc >= 30) begin
                        chk("step_timeout", 32'(dn[0] & dn[1]), 32'd1);
                        drv(0, 0, 0, 0, 0, 0, 0, 0);
                        drv(1, 0, 0, 0, 0, 0, 0, 0);
                        dn[0] = 1;
                        dn[1] = 1;
                    end else begin
                        nxt();
                        cyc++;
                    end
                end
            end
        end
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the IF stage (instruction fetch) and the MEM stage (LW/SW data access) of the pipelined processor. It serialises both requesters onto one fixed-latency unified memory. It raises a pipeline-wide `stall` until every pending request of the current pipeline step has been served. It honours `halt` from the `terminate` decode path so that no fetches are issued after program end.

## Interface
Parameters:
- `LAT`, default 2: memory access latency in cycles; legal range ≥1.
- `AW`, default 32: address width.

Ports (data width is `WORD`, 32):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `halt`  in  1  terminate seen; blocks new IF grants.
- `if_req`  in  1  fetch request, level.
- `if_addr`  in  AW  fetch address.
- `if_rdata`  out  WORD  fetched instruction, registered.
- `if_done`  out  1  fetch served for the current pipeline step.
- `d_req`  in  1  data request, level (LW or SW).
- `d_we`  in  1  1 = SW, 0 = LW.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  WORD  store data.
- `d_rdata`  out  WORD  load data, registered.
- `d_done`  out  1  data access served for the current pipeline step.
- `stall`  out  1  freeze all pipeline registers.
- `mem_en`  out  1  memory access active.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  WORD  memory write data.
- `mem_rdata`  in  WORD  memory read data; valid in the final access cycle.

## Operation
- States: IDLE, ACC_D, ACC_I. There is a down-counter `cnt` of width clog2(LAT)+1.
- Sticky served flags `d_ok` and `if_ok` drive `d_done` and `if_done` directly.
- Pending: `d_pend = d_req & ~d_ok`; `i_pend = if_req & ~if_ok & ~halt`.
- `stall = d_pend | i_pend | (state != IDLE)`. This is combinational.
- IDLE behaviour:
  - If `d_pend`, go to ACC_D.
  - Otherwise, if `i_pend`, go to ACC_I.
  - Otherwise, stay in IDLE.
  - On a grant, register `mem_en=1`, `mem_addr`, and `mem_we=d_we` (0 for IF). Register `mem_wdata` for D. Load `cnt=LAT-1`.
  - Data always has priority over fetch.
- ACC_x behaviour:
  - Hold the `mem_*` outputs stable.
  - While `cnt != 0`, decrement `cnt`.
  - At `cnt==0`:
    - Capture `mem_rdata` into `d_rdata` (for LW only; SW leaves `d_rdata` unchanged) or into `if_rdata`.
    - Set the matching `_ok` flag.
    - Clear `mem_en`/`mem_we`.
    - Go to IDLE.
- Flag clear: on any edge with `stall==0`, the pipeline advances. Both `_ok` flags clear on that edge. `if_rdata`/`d_rdata` hold their values.
- `halt` behaviour:
  - `halt` only masks new IF grants and removes IF from `stall`.
  - An ACC_I already in progress completes normally.
  - D requests are still served.
- Request inputs are sampled only on the grant edge. Later changes to them during ACC are ignored.
- Reset values:
  - State = IDLE, `cnt=0`.
  - `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `if_rdata=0`, `d_rdata=0`, `if_ok=0`, `d_ok=0`.
  - `stall` then follows the inputs.
- Reset mid-access aborts the access: `mem_en` is 0 the next cycle, no `_ok` flag is set, and no rdata is captured.

## Timing
- Single access, no contention, request first seen at cycle 0 in IDLE:
  - Cycles 1..LAT: `mem_en=1`.
  - End of cycle LAT: `mem_rdata` is sampled.
  - Cycle LAT+1: `_done=1`, rdata valid, `stall=0`.
  - The pipeline advances at the end of cycle LAT+1, and `_done` returns to 0 in cycle LAT+2.
  - Turn-around: LAT+2 cycles, with `stall` high for LAT+1 cycles.
- Both requests pending at cycle 0:
  - D occupies cycles 1..LAT.
  - Cycle LAT+1: IDLE, `d_done=1`, IF granted, `stall=1`.
  - I occupies cycles LAT+2..2LAT+1.
  - Cycle 2LAT+2: both `_done=1`, `stall=0`.
  - D is never re-issued while waiting for I.
- `mem_en` is never high for more than LAT consecutive cycles per grant. There is at least one IDLE cycle with `mem_en=0` between consecutive accesses.
- LAT=1: ACC lasts exactly one cycle.

## Test plan
- Reset with `if_req=1`, `if_addr=0x40`: all registered outputs are 0 during reset. After reset release, `mem_en=1` with `mem_addr=0x40` for 2 cycles, then `if_rdata` = memory[0x40] and `if_done=1` for exactly one cycle.
- Contention: `d_req=1`, `d_we=1`, `d_addr=0x100`, `d_wdata=0xDEADBEEF`, with `if_req=1` in the same cycle. Required order: the write to 0x100 occurs first, then the fetch. `stall` stays high until cycle 2LAT+2. Exactly one `mem_we` access to 0x100.
- LW followed by pipeline advance: `d_rdata` = memory[addr] when `d_done` is high. `d_rdata` holds its value after `d_done` clears. The next `d_req` with a new address is granted on the cycle after the advance.
- `halt=1` with `if_req=1` and no `d_req`: `stall=0`, `mem_en` stays 0 for 10 cycles. `halt` raised during ACC_I: that fetch still completes.
- Reset asserted during cycle 1 of ACC_D with LAT=3: `mem_en=0` on the next cycle, `d_done` never asserts, and the state is IDLE.
- Sweep LAT=1 and LAT=4 with random `if_req`/`d_req`/`halt` traffic: scoreboard each step gets exactly one access per pending port, data priority holds, and no duplicate accesses occur.
